mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single-word SRAM reads and writes on behalf of the
// control unit. Requests are accepted in IDLE and the address and write data
// are captured at that point. All SRAM strobes and handshake outputs come
// straight from flops, which are loaded from a decode of the current state.
// As a result, the pins show each state one cycle after the state register
// enters it.
// Optional feature: define MEM_ACCESS_CNT_EN to add the saturating
// Access_Count output.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        Mem_Ready,
    output logic        Busy,
    output logic [19:0] SRAM_ADDR,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] Data_to_SRAM,
    output logic        Data_OE,
`ifdef MEM_ACCESS_CNT_EN
    output logic [15:0] Access_Count,
`endif
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAP,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        cap_q, cap_d;
    logic        fin_q, fin_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic [19:0] sram_addr_q, sram_addr_d;
    logic [15:0] dout_q, dout_d;
    logic        data_oe_q, data_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;

    // Next-state logic, request acceptance and wait-cycle counting
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = 4'd0;
                if (Mem_WE) begin
                    state_d = WR_SETUP;
                    addr_d  = ADDR;
                    wdata_d = WDATA;
                end else if (Mem_OE) begin
                    state_d = RD_WAIT;
                    addr_d  = ADDR;
                    wdata_d = WDATA;
                end
            end
            RD_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = RD_CAP;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            RD_CAP: state_d = DONE;
            WR_SETUP: begin
                state_d    = WR_PULSE;
                wait_cnt_d = 4'd0;
            end
            WR_PULSE: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = WR_HOLD;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE: begin
                if (!Mem_OE && !Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the current state, loaded into the output flops so the pins show it next cycle
    always_comb begin
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        data_oe_d   = 1'b0;
        busy_d      = 1'b0;
        sram_addr_d = {4'b0000, addr_q};
        dout_d      = wdata_q;
        cap_d       = (state_q == RD_CAP);
        fin_d       = (state_q == RD_CAP) || (state_q == WR_HOLD);
        ready_d     = fin_q;
        rdata_d     = cap_q ? Data_from_SRAM : rdata_q;
        case (state_q)
            RD_WAIT, RD_CAP: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                ub_n_d = 1'b0;
                lb_n_d = 1'b0;
                busy_d = 1'b1;
            end
            WR_SETUP, WR_HOLD: begin
                ce_n_d    = 1'b0;
                ub_n_d    = 1'b0;
                lb_n_d    = 1'b0;
                data_oe_d = 1'b1;
                busy_d    = 1'b1;
            end
            WR_PULSE: begin
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                ub_n_d    = 1'b0;
                lb_n_d    = 1'b0;
                data_oe_d = 1'b1;
                busy_d    = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, latched request and registered outputs; reset parks every strobe inactive at once
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            addr_q      <= 16'd0;
            wdata_q     <= 16'd0;
            cap_q       <= 1'b0;
            fin_q       <= 1'b0;
            rdata_q     <= 16'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            sram_addr_q <= 20'd0;
            dout_q      <= 16'd0;
            data_oe_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cap_q       <= cap_d;
            fin_q       <= fin_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            sram_addr_q <= sram_addr_d;
            dout_q      <= dout_d;
            data_oe_q   <= data_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] access_cnt_q, access_cnt_d;

    // Count completed accesses alongside the ready pulse, sticking at all-ones
    always_comb begin
        access_cnt_d = access_cnt_q;
        if (fin_q && (access_cnt_q != 16'hFFFF)) begin
            access_cnt_d = access_cnt_q + 16'd1;
        end
    end

    // Access counter register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            access_cnt_q <= 16'd0;
        end else begin
            access_cnt_q <= access_cnt_d;
        end
    end

    assign Access_Count = access_cnt_q;
`endif

    assign RDATA        = rdata_q;
    assign Mem_Ready    = ready_q;
    assign Busy         = busy_q;
    assign SRAM_ADDR    = sram_addr_q;
    assign Data_to_SRAM = dout_q;
    assign Data_OE      = data_oe_q;
    assign SRAM_CE_N    = ce_n_q;
    assign SRAM_OE_N    = oe_n_q;
    assign SRAM_WE_N    = we_n_q;
    assign SRAM_UB_N    = ub_n_q;
    assign SRAM_LB_N    = lb_n_q;

endmodule
